iic_eeprom_slave: RTL and testbench
===================================

IIC_EEPROM_SLAVE -- requirements
Module: iic_eeprom_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, memory address width (24LC64-compatible map).
REQ-002 SHALL have parameter DEV_PREFIX, default 4'b1010, upper control-byte nibble.
REQ-003 SHALL have port clk50M, input, 1, sole clock (50 MHz); the block uses one clock.
REQ-004 SHALL have port reset, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port cs_bit, input, 3, device select compared with control bits [3:1].
REQ-006 SHALL have port scl, input, 1, IIC clock from master (asynchronous to clk50M).
REQ-007 SHALL have port sda, inout, 1, open-drain IIC data; driven only 0 or Z.
REQ-008 SHALL have port busy, output, 1, high from addressed START until STOP or NACK-terminated read.
REQ-009 SHALL have port wr_strobe, output, 1, one-cycle pulse per committed write byte.

Function
REQ-010 SHALL pass scl and sda through 2-flop synchronizers plus one delay flop; all edge detection uses synchronized values.
REQ-011 SHALL detect START as sync-sda falling while sync-scl high, and STOP as sync-sda rising while sync-scl high.
REQ-012 SHALL sample sda on sync-scl rising edge and change its sda drive only on sync-scl falling edge.
REQ-013 SHALL implement states IDLE, CTRL, CTRL_ACK, ADDR_H, ACK_H, ADDR_L, ACK_L, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-014 SHALL enter CTRL on any START, including repeated START in any state, and clear the bit counter.
REQ-015 SHALL enter IDLE on any STOP in any state and release sda within 1 clk of STOP detection.
REQ-016 CTRL: after 8 bits, SHALL go to CTRL_ACK if byte[7:4]==DEV_PREFIX and byte[3:1]==cs_bit, otherwise to IDLE without driving sda.
REQ-017 ACK states: SHALL drive sda low from the scl falling edge after bit 8 until the scl falling edge after bit 9.
REQ-018 After CTRL_ACK: R/W=0 -> ADDR_H; R/W=1 -> RD_DATA (current-address read).
REQ-019 ADDR_H: SHALL load bits [ADDR_W-9:0] into pointer high; bits [7:ADDR_W-8] are ignored. Then ACK_H -> ADDR_L.
REQ-020 ADDR_L: SHALL load pointer[7:0]. Then ACK_L -> WR_DATA.
REQ-021 WR_DATA: on the 8th bit's rising edge, SHALL write the byte to mem[ptr], pulse wr_strobe, increment ptr, then go to WR_ACK -> WR_DATA. Sequential writes are unlimited.
REQ-022 A START received in WR_DATA before bit 8 SHALL discard the partial byte (random-read dummy write).
REQ-023 RD_DATA: SHALL present mem[ptr] MSB-first, driving sda low for 0 bits and Z for 1 bits, each bit updated on scl falling edge. The first bit is valid before the first rising edge after ACK.
REQ-024 After 8 read bits, SHALL release sda and sample the master ACK on the 9th rising edge. ACK=0 -> increment ptr, back to RD_DATA. ACK=1 -> WAIT_STOP.
REQ-025 Pointer SHALL wrap from 2^ADDR_W-1 to 0 on every increment, for both read and write.
REQ-026 Pointer SHALL persist across transactions; only ADDR_H/ADDR_L and increments modify it.
REQ-027 Memory read latency SHALL be 1 clk; the read is issued on entry to RD_DATA and on each ACKed RD_ACK.
REQ-028 busy SHALL assert on entry to CTRL_ACK, and SHALL deassert in IDLE or WAIT_STOP.

Reset
REQ-029 On reset: state=IDLE, sda released (Z), busy=0, wr_strobe=0, ptr=0, bit counter=0, synchronizer flops=1.
REQ-030 Reset asserted mid-transaction SHALL release sda on the next clk edge. Memory contents are not cleared.
REQ-031 After reset, the block SHALL ignore bus activity until the next START.

Structure
REQ-032 Shared package iic_pkg SHALL hold DEV_PREFIX, the state enumeration, and the ACK/NACK level constants.
REQ-033 SHALL instantiate one sub-module, iic_slave_mem: single-port synchronous RAM, 2^ADDR_W x 8, 1-clk read latency.

Verification
REQ-034 Byte write: cs_bit=3'b001, master writes A2,00,10,5A, STOP -> all four ACKs low, mem[0x0010]=0x5A, one wr_strobe pulse.
REQ-035 Random read: after REQ-034, master sends A2,00,10, repeated START, A3, reads 1 byte, NACK -> read byte 0x5A, state WAIT_STOP then IDLE on STOP.
REQ-036 Wrong device: control byte A4 with cs_bit=3'b001 -> no ACK (sda stays high on 9th clock), busy=0, memory unchanged.
REQ-037 Wrap: write at address 0x1FFF bytes 11,22 -> mem[0x1FFF]=0x11, mem[0x0000]=0x22; sequential read of 2 from 0x1FFF returns 11,22.
REQ-038 Reset mid-read: assert reset while driving a 0 bit -> sda Z next clk, busy=0, ptr=0; subsequent current-address read returns mem[0].
REQ-039 Address high byte 0xFF -> pointer high = 0x1F (upper 3 bits ignored); verify by write/read at 0x1F00.

Source files
------------

// File: rtl/iic_pkg.sv
// Shared definitions for the IIC EEPROM slave: device prefix, bus levels, FSM states.
package iic_pkg;

  localparam logic [3:0] DEV_PREFIX = 4'b1010;
  localparam logic       ACK_LVL    = 1'b0;
  localparam logic       NACK_LVL   = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    CTRL,
    CTRL_ACK,
    ADDR_H,
    ACK_H,
    ADDR_L,
    ACK_L,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } iic_state_t;

endpackage

// File: rtl/iic_slave_mem.sv
// Single-port synchronous byte RAM backing the EEPROM image; reads take one clock.
module iic_slave_mem #(
  parameter int ADDR_W = 13
) (
  input  logic              clk50M,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  // Write on we, registered read on re; contents survive reset.
  always_ff @(posedge clk50M) begin
    if (we)
      mem[addr] <= wdata;
    if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/iic_eeprom_slave.sv
// 24LC64-style IIC EEPROM slave: synchronized bus sampling, byte-level FSM, pointer and RAM.
module iic_eeprom_slave
  import iic_pkg::*;
#(
  parameter int         ADDR_W     = 13,
  parameter logic [3:0] DEV_PREFIX = iic_pkg::DEV_PREFIX
) (
  input  logic       clk50M,
  input  logic       reset,
  input  logic [2:0] cs_bit,
  input  logic       scl,
  inout  wire        sda,
  output logic       busy,
  output logic       wr_strobe
);

  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  iic_state_t        state;
  logic [2:0]        bit_cnt;
  logic [6:0]        shift;
  logic [7:0]        rx_byte;
  logic              dev_match;
  logic              rw;
  logic              sda_oe;
  logic [ADDR_W-1:0] ptr;

  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata, rd_data;

  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Bring scl/sda into the clk50M domain and keep one delayed copy for edge detection.
  always_ff @(posedge clk50M) begin
    if (reset) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_s1 <= scl;    scl_s2 <= scl_s1; scl_d <= scl_s2;
      sda_s1 <= sda;    sda_s2 <= sda_s1; sda_d <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & ~sda_d & sda_s2;
  assign rx_byte   = {shift, sda_s2};
  assign dev_match = (rx_byte[7:4] == DEV_PREFIX) && (rx_byte[3:1] == cs_bit);

  // Protocol FSM: bus conditions take priority, then per-state handling of scl edges.
  always_ff @(posedge clk50M) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift     <= 7'd0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      ptr       <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'd0;
    end else begin
      wr_strobe <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      if (stop_det) begin
        state   <= IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= 3'd0;
      end else if (start_det) begin
        state   <= CTRL;
        sda_oe  <= 1'b0;
        bit_cnt <= 3'd0;
      end else begin
        case (state)
          CTRL, ADDR_H, ADDR_L, WR_DATA: begin
            if (scl_fall)
              sda_oe <= 1'b0;
            if (scl_rise) begin
              shift   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                bit_cnt <= 3'd0;
                if (state == CTRL) begin
                  if (dev_match) begin
                    state <= CTRL_ACK;
                    busy  <= 1'b1;
                    rw    <= rx_byte[0];
                  end else begin
                    state <= IDLE;
                  end
                end else if (state == ADDR_H) begin
                  ptr[ADDR_W-1:8] <= rx_byte[ADDR_W-9:0];
                  state           <= ACK_H;
                end else if (state == ADDR_L) begin
                  ptr[7:0] <= rx_byte;
                  state    <= ACK_L;
                end else begin
                  mem_addr  <= ptr;
                  mem_wdata <= rx_byte;
                  mem_we    <= 1'b1;
                  wr_strobe <= 1'b1;
                  ptr       <= ptr + PTR_ONE;
                  state     <= WR_ACK;
                end
              end
            end
          end
          CTRL_ACK, ACK_H, ACK_L, WR_ACK: begin
            if (scl_fall)
              sda_oe <= 1'b1;
            if (scl_rise) begin
              if (state == CTRL_ACK) begin
                if (rw) begin
                  state    <= RD_DATA;
                  mem_re   <= 1'b1;
                  mem_addr <= ptr;
                end else begin
                  state <= ADDR_H;
                end
              end else if (state == ACK_H) begin
                state <= ADDR_L;
              end else begin
                state <= WR_DATA;
              end
            end
          end
          RD_DATA: begin
            if (scl_fall)
              sda_oe <= ~rd_data[3'd7 - bit_cnt];
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                bit_cnt <= 3'd0;
                state   <= RD_ACK;
              end
            end
          end
          RD_ACK: begin
            if (scl_fall)
              sda_oe <= 1'b0;
            if (scl_rise) begin
              if (sda_s2 == ACK_LVL) begin
                ptr      <= ptr + PTR_ONE;
                mem_addr <= ptr + PTR_ONE;
                mem_re   <= 1'b1;
                state    <= RD_DATA;
              end else begin
                state <= WAIT_STOP;
                busy  <= 1'b0;
              end
            end
          end
          default: begin
            sda_oe <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

  iic_slave_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk50M (clk50M),
    .we     (mem_we),
    .re     (mem_re),
    .addr   (mem_addr),
    .wdata  (mem_wdata),
    .rdata  (rd_data)
  );

endmodule

// File: tb/tb_iic_eeprom_slave.sv
// Directed bench for iic_eeprom_slave: bit-banged IIC master with hand-computed expectations.
module tb_iic_eeprom_slave;
  import iic_pkg::*;

  logic       clk50M = 1'b0;
  logic       reset;
  logic [2:0] cs_bit;
  logic       scl;
  logic       m_sda_oe;
  wire        sda;
  logic       busy;
  logic       wr_strobe;

  int         total = 0;
  int         bad = 0;
  int         strobes = 0;
  int         strobes_ref;
  logic       ack;
  logic [7:0] rd;

  assign sda = m_sda_oe ? 1'b0 : 1'bz;
  pullup(sda);

  // 50 MHz clock
  always #10 clk50M = ~clk50M;

  // Count write strobe pulses
  always @(negedge clk50M) begin
    if (wr_strobe)
      strobes = strobes + 1;
  end

  // Overall time limit
  initial begin
    #4ms;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  iic_eeprom_slave #(.ADDR_W(13), .DEV_PREFIX(4'b1010)) dut (
    .clk50M    (clk50M),
    .reset     (reset),
    .cs_bit    (cs_bit),
    .scl       (scl),
    .sda       (sda),
    .busy      (busy),
    .wr_strobe (wr_strobe)
  );

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total = total + 1;
    if (observed !== expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s observed=%0h required=%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk50M);
  endtask

  task automatic iic_start();
    m_sda_oe = 1'b0; wait_clks(5);
    scl = 1'b1;      wait_clks(10);
    m_sda_oe = 1'b1; wait_clks(10);
    scl = 1'b0;      wait_clks(5);
  endtask

  task automatic iic_stop();
    m_sda_oe = 1'b1; wait_clks(5);
    scl = 1'b1;      wait_clks(10);
    m_sda_oe = 1'b0; wait_clks(10);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    m_sda_oe = ~b; wait_clks(5);
    scl = 1'b1;    wait_clks(5);
    s = sda;       wait_clks(5);
    scl = 1'b0;    wait_clks(5);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic a);
    logic s;
    for (int i = 7; i >= 0; i--)
      bus_bit(b[i], s);
    bus_bit(1'b1, a);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bus_bit(1'b1, s);
      d = {d[6:0], s};
    end
    bus_bit(master_ack, s);
  endtask

  // START, control A2, two address bytes, each ACK checked
  task automatic addr_phase(input logic [7:0] hi, input logic [7:0] lo);
    logic a;
    iic_start();
    write_byte(8'hA2, a); check_output("ap_ctrl_ack", a, 1'b0);
    write_byte(hi, a);    check_output("ap_hi_ack", a, 1'b0);
    write_byte(lo, a);    check_output("ap_lo_ack", a, 1'b0);
  endtask

  initial begin
    reset = 1'b1; scl = 1'b1; m_sda_oe = 1'b0; cs_bit = 3'b001;
    wait_clks(4);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_strobe", wr_strobe, 1'b0);
    check_output("rst_sda", sda, 1'b1);
    check_output("rst_ptr", dut.ptr, 13'h0000);
    check_output("rst_state", dut.state, IDLE);
    reset = 1'b0;
    wait_clks(4);

    // Byte write A2,00,10,5A
    strobes_ref = strobes;
    iic_start();
    write_byte(8'hA2, ack); check_output("bw_ctrl_ack", ack, 1'b0);
    check_output("bw_busy", busy, 1'b1);
    write_byte(8'h00, ack); check_output("bw_hi_ack", ack, 1'b0);
    write_byte(8'h10, ack); check_output("bw_lo_ack", ack, 1'b0);
    write_byte(8'h5A, ack); check_output("bw_data_ack", ack, 1'b0);
    iic_stop();
    check_output("bw_strobes", strobes - strobes_ref, 1);
    check_output("bw_busy_after", busy, 1'b0);
    check_output("bw_mem", dut.u_mem.mem[13'h0010], 8'h5A);

    // Random read from 0x0010 with dummy write
    strobes_ref = strobes;
    addr_phase(8'h00, 8'h10);
    iic_start();
    write_byte(8'hA3, ack); check_output("rr_ctrl_ack", ack, 1'b0);
    read_byte(1'b1, rd);
    check_output("rr_data", rd, 8'h5A);
    check_output("rr_state", dut.state, WAIT_STOP);
    check_output("rr_busy", busy, 1'b0);
    iic_stop();
    check_output("rr_idle", dut.state, IDLE);
    check_output("rr_no_strobe", strobes - strobes_ref, 0);

    // Wrong device select
    strobes_ref = strobes;
    iic_start();
    write_byte(8'hA4, ack); check_output("wd_nack", ack, 1'b1);
    check_output("wd_busy", busy, 1'b0);
    write_byte(8'h00, ack);
    write_byte(8'h10, ack);
    write_byte(8'hEE, ack); check_output("wd_data_nack", ack, 1'b1);
    iic_stop();
    check_output("wd_strobes", strobes - strobes_ref, 0);
    check_output("wd_mem", dut.u_mem.mem[13'h0010], 8'h5A);

    // Pointer wrap on write at 0x1FFF
    strobes_ref = strobes;
    addr_phase(8'h1F, 8'hFF);
    write_byte(8'h11, ack); check_output("wr_ack1", ack, 1'b0);
    write_byte(8'h22, ack); check_output("wr_ack2", ack, 1'b0);
    iic_stop();
    check_output("wr_strobes", strobes - strobes_ref, 2);
    check_output("wr_mem_top", dut.u_mem.mem[13'h1FFF], 8'h11);
    check_output("wr_mem_zero", dut.u_mem.mem[13'h0000], 8'h22);

    // Sequential read of two bytes across the wrap
    addr_phase(8'h1F, 8'hFF);
    iic_start();
    write_byte(8'hA3, ack); check_output("sr_ctrl_ack", ack, 1'b0);
    read_byte(1'b0, rd); check_output("sr_byte0", rd, 8'h11);
    read_byte(1'b1, rd); check_output("sr_byte1", rd, 8'h22);
    iic_stop();

    // Reset while the slave drives a 0 bit (MSB of 0x5A)
    addr_phase(8'h00, 8'h10);
    iic_start();
    write_byte(8'hA3, ack); check_output("rm_ctrl_ack", ack, 1'b0);
    check_output("rm_bit7_low", sda, 1'b0);
    reset = 1'b1;
    @(posedge clk50M); #1;
    check_output("rm_sda_rel", sda, 1'b1);
    check_output("rm_busy", busy, 1'b0);
    check_output("rm_ptr", dut.ptr, 13'h0000);
    wait_clks(2);
    reset = 1'b0;
    wait_clks(2);
    iic_stop();
    iic_start();
    write_byte(8'hA3, ack); check_output("rm_ca_ack", ack, 1'b0);
    read_byte(1'b1, rd); check_output("rm_ca_data", rd, 8'h22);
    iic_stop();

    // High address byte 0xFF maps to 0x1F
    addr_phase(8'hFF, 8'h00);
    write_byte(8'h77, ack); check_output("hi_data_ack", ack, 1'b0);
    iic_stop();
    check_output("hi_mem", dut.u_mem.mem[13'h1F00], 8'h77);
    addr_phase(8'h1F, 8'h00);
    iic_start();
    write_byte(8'hA3, ack); check_output("hi_rd_ack", ack, 1'b0);
    read_byte(1'b1, rd); check_output("hi_rd_data", rd, 8'h77);
    iic_stop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
